regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the 32x32 register file.
- Merges writeback results from two producers into the file's single write port:
  - channel A: ALU, single-cycle results
  - channel B: load/store unit, multi-cycle results
- Uses round-robin valid/ready arbitration.
- Keeps a busy-bit scoreboard of destination registers with outstanding results, which issue logic uses for RAW/WAW hazard detection.

Parameters:
- DATA_W, 32, writeback data width (matches register file word)
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- iwClk  in  1  clock; this block uses the posedge only, the register file writes on the following negedge
- iwnRst  in  1  reset, asynchronous, active-low
- iwIssueValid  in  1  issue logic claims destination iwIssueReg
- iwIssueReg  in  ADDR_W  destination register being issued
- owIssueStall  out  1  issue refused, WAW on a busy register
- iwAValid  in  1  channel A result valid
- iwAReg  in  ADDR_W  channel A destination
- iwAData  in  DATA_W  channel A result
- owAReady  out  1  channel A accepted this cycle
- iwBValid, iwBReg, iwBData, owBReady  as channel A, for channel B
- owWriteEnable  out  1  to register file write enable
- owWriteReg  out  ADDR_W  to register file write index
- owWriteData  out  DATA_W  to register file write data
- owBusy  out  NUM_REGS  scoreboard, bit i set means register i has a pending result
- owSbErr  out  1  sticky: writeback to a register that was not busy

Behaviour:
- Reset (async, iwnRst low), all outputs and state cleared:
  - owWriteEnable=0, owWriteReg=0, owWriteData=0
  - owBusy=0, owSbErr=0
  - round-robin pointer = "last granted B", so A wins the first conflict
- Arbitration is combinational within a cycle:
  - only A valid: grant A
  - only B valid: grant B
  - both valid: grant the channel not granted last; pointer updates only on a contested or uncontested grant
- owXReady equals the grant for that channel. A transfer completes on a posedge with valid and ready both high. Producers hold valid/reg/data until ready.
- At most one writeback per cycle; the write port never back-pressures.
- Output stage is registered; latency is 1 cycle from grant edge to the owWriteEnable pulse.
  - On a grant edge: owWriteEnable<=1, and owWriteReg/owWriteData load the granted channel's values.
  - With no grant: owWriteEnable<=0; owWriteReg/owWriteData hold their values.
  - The register file captures on the next negedge, so a combinational read later in the same cycle sees the new value.
- Register 0:
  - An accepted writeback to reg 0 completes the handshake but produces owWriteEnable=0 and leaves the scoreboard unchanged.
  - Issue to reg 0 never sets busy and never stalls.
- Scoreboard, updated at posedge:
  - Set bit r when iwIssueValid && !owIssueStall && r!=0.
  - Clear bit r on an accepted writeback to r.
  - Same-cycle issue and writeback to the same r: the bit ends set (new issue wins). No stall in this case, because the write retires that cycle.
- owIssueStall = iwIssueValid && busy[iwIssueReg] && !(accepted writeback to iwIssueReg this cycle). It is combinational.
- An accepted writeback to a non-busy, nonzero register is still written, and sets owSbErr. owSbErr stays set until reset.
- Reset mid-operation: any pending output write is discarded (owWriteEnable drops immediately); all busy bits clear.

Decomposition:
- Shared package holds:
  - constants DATA_W, ADDR_W, NUM_REGS
  - REG_ZERO = 0
  - a channel-select enum (CH_A, CH_B) for the grant pointer
- One natural sub-module, rr_arbiter_2: a 2-requester round-robin arbiter with a registered pointer that outputs a one-hot grant.
- Scoreboard and output register stay in the top.

Test Plan:
- Reset, then idle: owBusy=0, owWriteEnable=0; issue reg 5 -> owBusy[5]=1 next cycle.
- A valid reg 5 data 0xDEADBEEF -> owAReady=1 the same cycle; next cycle owWriteEnable=1, owWriteReg=5, owWriteData=0xDEADBEEF, owBusy[5]=0.
- A and B valid for 4 consecutive cycles (regs 1..4, each pre-issued) -> grants A,B,A,B; each channel is stalled every other cycle with data held.
- Issue reg 7 while busy[7]=1 with no writeback -> owIssueStall=1 and busy unchanged. Issue reg 7 in the same cycle as writeback to 7 -> no stall, busy[7] stays 1.
- B writeback to reg 0 -> owBReady=1, owWriteEnable stays 0. Writeback to non-busy reg 9 -> write occurs and owSbErr=1 sticky.
- iwnRst pulsed low mid-cycle while owWriteEnable=1 and owBusy=0x0000_00A0 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Imported by the interface, the round-robin arbiter and the top.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Identifies which producer channel was granted most recently.
    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/issue bundle between the producers, the issue logic and the arbiter.
// The slave modport is the arbiter's view; master is the producers' and issue logic's view.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                iwIssueValid;
    logic [ADDR_W-1:0]   iwIssueReg;
    logic                owIssueStall;

    logic                iwAValid;
    logic [ADDR_W-1:0]   iwAReg;
    logic [DATA_W-1:0]   iwAData;
    logic                owAReady;

    logic                iwBValid;
    logic [ADDR_W-1:0]   iwBReg;
    logic [DATA_W-1:0]   iwBData;
    logic                owBReady;

    logic                owWriteEnable;
    logic [ADDR_W-1:0]   owWriteReg;
    logic [DATA_W-1:0]   owWriteData;

    logic [NUM_REGS-1:0] owBusy;
    logic                owSbErr;

    modport slave (
        input  iwIssueValid, iwIssueReg,
        output owIssueStall,
        input  iwAValid, iwAReg, iwAData,
        output owAReady,
        input  iwBValid, iwBReg, iwBData,
        output owBReady,
        output owWriteEnable, owWriteReg, owWriteData,
        output owBusy, owSbErr
    );

    modport master (
        output iwIssueValid, iwIssueReg,
        input  owIssueStall,
        output iwAValid, iwAReg, iwAData,
        input  owAReady,
        output iwBValid, iwBReg, iwBData,
        input  owBReady,
        input  owWriteEnable, owWriteReg, owWriteData,
        input  owBusy, owSbErr
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Grant is combinational and one-hot; bit 0 is channel A, bit 1 is channel B.
module rr_arbiter_2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    ch_e last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == CH_B) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = CH_A;
        end else if (gnt_o[1]) begin
            last_d = CH_B;
        end
    end

    // Reset to "B granted last" so A wins the first contested cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= CH_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (A) and LSU (B) writebacks into the register file's single write port
// and tracks destination registers with outstanding results in a busy scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 iwClk,
    input  logic                 iwnRst,
    regfile_wb_arbiter_if.slave  wb
);

    logic [1:0]          gnt;
    logic                acc;
    logic                acc_live;
    logic [ADDR_W-1:0]   acc_reg;
    logic [DATA_W-1:0]   acc_data;
    logic                issue_stall;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                sb_err_q, sb_err_d;

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk_i  (iwClk),
        .rst_ni (iwnRst),
        .req_i  ({wb.iwBValid, wb.iwAValid}),
        .gnt_o  (gnt)
    );

    always_comb begin
        acc      = |gnt;
        acc_reg  = gnt[1] ? wb.iwBReg  : wb.iwAReg;
        acc_data = gnt[1] ? wb.iwBData : wb.iwAData;
        // Writes to register 0 complete the handshake but are otherwise dropped.
        acc_live = acc && (acc_reg != REG_ZERO);

        // A writeback retiring the same register this cycle frees it for the new issue.
        issue_stall = wb.iwIssueValid && busy_q[wb.iwIssueReg]
                      && !(acc && (acc_reg == wb.iwIssueReg));

        busy_d = busy_q;
        if (acc_live) begin
            busy_d[acc_reg] = 1'b0;
        end
        if (wb.iwIssueValid && !issue_stall && (wb.iwIssueReg != REG_ZERO)) begin
            busy_d[wb.iwIssueReg] = 1'b1;
        end

        sb_err_d = sb_err_q || (acc_live && !busy_q[acc_reg]);

        wr_en_d   = acc_live;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (acc_live) begin
            wr_reg_d  = acc_reg;
            wr_data_d = acc_data;
        end
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign wb.owAReady      = gnt[0];
    assign wb.owBReady      = gnt[1];
    assign wb.owIssueStall  = issue_stall;
    assign wb.owWriteEnable = wr_en_q;
    assign wb.owWriteReg    = wr_reg_q;
    assign wb.owWriteData   = wr_data_q;
    assign wb.owBusy        = busy_q;
    assign wb.owSbErr       = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, mid-cycle reset sequence,
// then randomized traffic checked against a scoreboard/arbitration model.
module tb_regfile_wb_arbiter;

    logic iwClk;
    logic iwnRst;

    regfile_wb_arbiter_if wb_if ();

    regfile_wb_arbiter dut (
        .iwClk  (iwClk),
        .iwnRst (iwnRst),
        .wb     (wb_if)
    );

    initial iwClk = 1'b0;
    always #5 iwClk = ~iwClk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int iv, input int ir, input int av, input int ar,
                         input logic [31:0] ad, input int bv, input int br,
                         input logic [31:0] bd);
        wb_if.iwIssueValid = 1'(iv);
        wb_if.iwIssueReg   = 5'(ir);
        wb_if.iwAValid     = 1'(av);
        wb_if.iwAReg       = 5'(ar);
        wb_if.iwAData      = ad;
        wb_if.iwBValid     = 1'(bv);
        wb_if.iwBReg       = 5'(br);
        wb_if.iwBData      = bd;
    endtask

    // Directed vectors: inputs for one cycle, combinational expectations in that cycle,
    // registered expectations after the following posedge.
    typedef struct {
        int          iv, ir, av, ar;
        logic [31:0] ad;
        int          bv, br;
        logic [31:0] bd;
        int          e_ar, e_br, e_st, e_we, chk_w, e_wreg;
        logic [31:0] e_wdata, e_busy;
        int          e_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] m_busy;
    logic        m_err, m_we, m_known;
    int          m_last;  // 0: A granted last, 1: B granted last
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    task automatic model_reset();
        m_busy = '0; m_err = 1'b0; m_we = 1'b0; m_known = 1'b1;
        m_last = 1; m_wreg = '0; m_wdata = '0;
    endtask

    task automatic model_cycle(input int iv, input int ir, input int av, input int ar,
                               input logic [31:0] ad, input int bv, input int br,
                               input logic [31:0] bd, output int g);
        int          greg;
        logic [31:0] gdata;
        logic        st;
        drive(iv, ir, av, ar, ad, bv, br, bd);
        if (av != 0 && bv != 0) g = (m_last == 1) ? 1 : 2;
        else if (av != 0)       g = 1;
        else if (bv != 0)       g = 2;
        else                    g = 0;
        greg  = (g == 2) ? br : ar;
        gdata = (g == 2) ? bd : ad;
        st = (iv != 0) && m_busy[ir] && !(g != 0 && greg == ir);
        #2;
        chk("rnd_a_ready", 32'(wb_if.owAReady), 32'(g == 1));
        chk("rnd_b_ready", 32'(wb_if.owBReady), 32'(g == 2));
        chk("rnd_stall",   32'(wb_if.owIssueStall), 32'(st));
        @(posedge iwClk);
        #1;
        m_we = 1'b0;
        if (g != 0) begin
            m_last = g - 1;
            if (greg != 0) begin
                if (!m_busy[greg]) m_err = 1'b1;
                m_busy[greg] = 1'b0;
                m_we = 1'b1; m_wreg = 5'(greg); m_wdata = gdata; m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
        if (iv != 0 && !st && ir != 0) m_busy[ir] = 1'b1;
        chk("rnd_we",   32'(wb_if.owWriteEnable), 32'(m_we));
        chk("rnd_busy", wb_if.owBusy, m_busy);
        chk("rnd_err",  32'(wb_if.owSbErr), 32'(m_err));
        if (m_known) begin
            chk("rnd_wreg",  32'(wb_if.owWriteReg), 32'(m_wreg));
            chk("rnd_wdata", wb_if.owWriteData, m_wdata);
        end
    endtask

    function automatic int pick_reg();
        int q[$];
        for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 4) != 0) return q[$urandom_range(0, q.size() - 1)];
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        int          g;
        int          apend, areg, bpend, breg;
        logic [31:0] adata, bdata;

        //           iv ir av ar ad            bv br bd            ar br st we cw wr wdata         busy        err
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h0,        32'h0,     0});
        vecs.push_back('{1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 32'h0,        32'h20,    0});
        vecs.push_back('{0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 0, 1, 1, 5, 32'hDEADBEEF, 32'h0,     0});
        vecs.push_back('{1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h2,     0});
        vecs.push_back('{1, 2, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h6,     0});
        vecs.push_back('{1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'hE,     0});
        vecs.push_back('{1, 4, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h1E,    0});
        vecs.push_back('{1, 6, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h5E,    0});
        vecs.push_back('{1, 8, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h15E,   0});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 6, 32'h66,       0, 1, 0, 1, 1, 6, 32'h66,       32'h11E,   0});
        vecs.push_back('{0, 0, 1, 1, 32'hA1,       1, 2, 32'hB2,       1, 0, 0, 1, 1, 1, 32'hA1,       32'h11C,   0});
        vecs.push_back('{0, 0, 1, 3, 32'hA3,       1, 2, 32'hB2,       0, 1, 0, 1, 1, 2, 32'hB2,       32'h118,   0});
        vecs.push_back('{0, 0, 1, 3, 32'hA3,       1, 4, 32'hB4,       1, 0, 0, 1, 1, 3, 32'hA3,       32'h110,   0});
        vecs.push_back('{0, 0, 1, 8, 32'hA8,       1, 4, 32'hB4,       0, 1, 0, 1, 1, 4, 32'hB4,       32'h100,   0});
        vecs.push_back('{0, 0, 1, 8, 32'hA8,       0, 0, 32'h0,        1, 0, 0, 1, 1, 8, 32'hA8,       32'h0,     0});
        vecs.push_back('{1, 7, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 8, 32'hA8,       32'h80,    0});
        vecs.push_back('{1, 7, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 0, 1, 8, 32'hA8,       32'h80,    0});
        vecs.push_back('{1, 7, 1, 7, 32'h77,       0, 0, 32'h0,        1, 0, 0, 1, 1, 7, 32'h77,       32'h80,    0});
        vecs.push_back('{1, 0, 0, 0, 32'h0,        1, 0, 32'h12345678, 0, 1, 0, 0, 0, 0, 32'h0,        32'h80,    0});
        vecs.push_back('{0, 0, 1, 9, 32'h99,       0, 0, 32'h0,        1, 0, 0, 1, 1, 9, 32'h99,       32'h80,    1});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 9, 32'h99,       32'h80,    1});
        vecs.push_back('{1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 1, 9, 32'h99,       32'hA0,    1});
        vecs.push_back('{0, 0, 0, 0, 32'h0,        1, 10, 32'hAA,      0, 1, 0, 1, 1, 10, 32'hAA,      32'hA0,    1});
        vecs.push_back('{0, 0, 1, 11, 32'hBB,      0, 0, 32'h0,        1, 0, 0, 1, 1, 11, 32'hBB,      32'hA0,    1});

        iwnRst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        repeat (3) @(posedge iwClk);
        #1;
        chk("rst_we",   32'(wb_if.owWriteEnable), 32'h0);
        chk("rst_busy", wb_if.owBusy, 32'h0);
        chk("rst_err",  32'(wb_if.owSbErr), 32'h0);
        @(negedge iwClk);
        iwnRst = 1'b1;
        @(posedge iwClk);
        #1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.iv, v.ir, v.av, v.ar, v.ad, v.bv, v.br, v.bd);
            #2;
            chk($sformatf("v%0d_a_ready", i), 32'(wb_if.owAReady), 32'(v.e_ar));
            chk($sformatf("v%0d_b_ready", i), 32'(wb_if.owBReady), 32'(v.e_br));
            chk($sformatf("v%0d_stall", i),   32'(wb_if.owIssueStall), 32'(v.e_st));
            @(posedge iwClk);
            #1;
            chk($sformatf("v%0d_we", i),   32'(wb_if.owWriteEnable), 32'(v.e_we));
            chk($sformatf("v%0d_busy", i), wb_if.owBusy, v.e_busy);
            chk($sformatf("v%0d_err", i),  32'(wb_if.owSbErr), 32'(v.e_err));
            if (v.chk_w != 0) begin
                chk($sformatf("v%0d_wreg", i),  32'(wb_if.owWriteReg), 32'(v.e_wreg));
                chk($sformatf("v%0d_wdata", i), wb_if.owWriteData, v.e_wdata);
            end
        end

        // Asynchronous reset mid-cycle while a write is pending and busy=0xA0.
        drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        #3;
        iwnRst = 1'b0;
        #1;
        chk("arst_we",      32'(wb_if.owWriteEnable), 32'h0);
        chk("arst_wreg",    32'(wb_if.owWriteReg), 32'h0);
        chk("arst_wdata",   wb_if.owWriteData, 32'h0);
        chk("arst_busy",    wb_if.owBusy, 32'h0);
        chk("arst_err",     32'(wb_if.owSbErr), 32'h0);
        chk("arst_stall",   32'(wb_if.owIssueStall), 32'h0);
        chk("arst_a_ready", 32'(wb_if.owAReady), 32'h0);
        chk("arst_b_ready", 32'(wb_if.owBReady), 32'h0);
        @(posedge iwClk);
        #1;
        chk("arst_we_hold", 32'(wb_if.owWriteEnable), 32'h0);
        #2;
        iwnRst = 1'b1;
        @(posedge iwClk);
        #1;

        // Pointer was "A last" before reset; reset must restore A priority.
        model_reset();
        model_cycle(1, 12, 0, 0, 32'h0, 0, 0, 32'h0, g);
        model_cycle(1, 13, 0, 0, 32'h0, 0, 0, 32'h0, g);
        model_cycle(0, 0, 1, 12, 32'hC12, 1, 13, 32'hC13, g);
        chk("post_rst_grant", 32'(g), 32'd1);

        apend = 0; areg = 0; adata = '0;
        bpend = 1; breg = 13; bdata = 32'hC13;
        for (int c = 0; c < 400; c++) begin
            int iv, ir;
            if (apend == 0 && $urandom_range(0, 2) != 0) begin
                apend = 1; areg = pick_reg(); adata = $urandom;
            end
            if (bpend == 0 && $urandom_range(0, 2) != 0) begin
                bpend = 1; breg = pick_reg(); bdata = $urandom;
            end
            iv = ($urandom_range(0, 2) == 0) ? 1 : 0;
            ir = int'($urandom_range(0, 31));
            model_cycle(iv, ir, apend, areg, adata, bpend, breg, bdata, g);
            if (g == 1) apend = 0;
            if (g == 2) bpend = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
